// File: rtl/cdu_pkg.sv
// Shared widths, defaults and error-drive state encoding for the AGC-side CDU interface.
package cdu_pkg;
  localparam int ANGLE_W     = 15;
  localparam int ERR_W       = 11;
  localparam int REM_W       = 10;
  localparam int ERR_MAX_DEF = 384;
  localparam int PERIOD_DEF  = 320;
  localparam int WIDTH_DEF   = 3;
  localparam int ZERO_DEF    = 5120;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } err_state_t;

  // Magnitude of a two's-complement count; -1024 maps to 1024 as an unsigned value.
  function automatic logic [ERR_W-1:0] abs_count(input logic [ERR_W-1:0] c);
    return c[ERR_W-1] ? (~c + 1'b1) : c;
  endfunction
endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer for an asynchronous pulse line, followed by a registered rising-edge strobe.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_pulse,
  output logic o_rise
);
  logic r_meta, r_sync, r_prev, r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_meta <= i_pulse;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
    end
  end

  assign o_rise = r_rise;
endmodule

// File: rtl/agc_cdu_interface.sv
// AGC-side CDU companion: accumulates CDU angle pulses and generates error-counter drive
// pulse trains plus the AGCZ / AGCEEC moding lines.
module agc_cdu_interface
  import cdu_pkg::*;
#(
  parameter int PERIOD_CYC = PERIOD_DEF,
  parameter int WIDTH_CYC  = WIDTH_DEF,
  parameter int ZERO_CYC   = ZERO_DEF,
  parameter int ERR_MAX    = ERR_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ATpPGH,
  input  logic               ATmPGH,
  output logic [ANGLE_W-1:0] angle,
  output logic               dual_pulse_err,
  input  logic               zero_req,
  input  logic               ec_enable,
  input  logic               err_valid,
  input  logic [ERR_W-1:0]   err_count,
  output logic               err_ready,
  input  logic               err_abort,
  output logic               err_sat,
  output logic [REM_W-1:0]   err_remaining,
  output logic               AFpPCH,
  output logic               AFmPCH,
  output logic               AGCZ,
  output logic               AGCEEC
);
  localparam int CNT_W  = $clog2(PERIOD_CYC);
  localparam int ZCNT_W = $clog2(ZERO_CYC + 1);

  logic               w_p_rise, w_m_rise;
  logic [ANGLE_W-1:0] r_angle;
  logic               r_dual;
  logic               r_agcz;
  logic [ZCNT_W-1:0]  r_zcnt;
  logic               r_eec;

  pulse_sync_edge u_sync_p (.clk(clk), .rst(rst), .i_pulse(ATpPGH), .o_rise(w_p_rise));
  pulse_sync_edge u_sync_m (.clk(clk), .rst(rst), .i_pulse(ATmPGH), .o_rise(w_m_rise));

  // Angle is forced to zero from the zero request onward, discarding any edges that arrive meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_angle <= '0;
      r_dual  <= 1'b0;
    end else if (zero_req || !r_agcz) begin
      r_angle <= '0;
    end else if (w_p_rise && w_m_rise) begin
      r_dual <= 1'b1;
    end else if (w_p_rise) begin
      r_angle <= r_angle + 1'b1;
    end else if (w_m_rise) begin
      r_angle <= r_angle - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_agcz <= 1'b1;
      r_zcnt <= '0;
      r_eec  <= 1'b1;
    end else begin
      r_eec <= ~ec_enable;
      if (zero_req) begin
        r_agcz <= 1'b0;
        r_zcnt <= ZCNT_W'(ZERO_CYC - 1);
      end else if (r_zcnt != '0) begin
        r_zcnt <= r_zcnt - 1'b1;
      end else begin
        r_agcz <= 1'b1;
      end
    end
  end

  err_state_t       r_state;
  logic             r_ready, r_dir, r_abort_pend, r_sat, r_afp, r_afm;
  logic [REM_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept, w_over;
  logic [ERR_W-1:0] w_mag, w_mag_clamp;

  assign w_accept    = err_valid & ~err_abort & (r_state == IDLE);
  assign w_mag       = abs_count(err_count);
  assign w_over      = w_mag > ERR_W'(ERR_MAX);
  assign w_mag_clamp = w_over ? ERR_W'(ERR_MAX) : w_mag;

  // r_cnt counts cycles since the current pulse's rising edge, spanning both HIGH and GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_dir        <= 1'b0;
      r_abort_pend <= 1'b0;
      r_sat        <= 1'b0;
      r_afp        <= 1'b0;
      r_afm        <= 1'b0;
      r_rem        <= '0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_over) r_sat <= 1'b1;
            if (w_mag != '0) begin
              r_state      <= HIGH;
              r_ready      <= 1'b0;
              r_dir        <= err_count[ERR_W-1];
              r_rem        <= REM_W'(w_mag_clamp - 1'b1);
              r_cnt        <= '0;
              r_afp        <= ~err_count[ERR_W-1];
              r_afm        <= err_count[ERR_W-1];
              r_abort_pend <= 1'b0;
            end
          end
        end
        HIGH: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH_CYC - 1)) begin
            r_afp <= 1'b0;
            r_afm <= 1'b0;
            if (r_abort_pend || err_abort) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_rem   <= '0;
            end else begin
              r_state <= GAP;
            end
          end else if (err_abort) begin
            r_abort_pend <= 1'b1;
          end
        end
        GAP: begin
          if (err_abort) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_rem   <= '0;
          end else if (r_cnt == CNT_W'(PERIOD_CYC - 1)) begin
            if (r_rem != '0) begin
              r_state <= HIGH;
              r_cnt   <= '0;
              r_rem   <= r_rem - 1'b1;
              r_afp   <= ~r_dir;
              r_afm   <= r_dir;
            end else begin
              r_state <= IDLE;
              r_ready <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_afp   <= 1'b0;
          r_afm   <= 1'b0;
        end
      endcase
    end
  end

  assign angle          = r_angle;
  assign dual_pulse_err = r_dual;
  assign err_ready      = r_ready;
  assign err_sat        = r_sat;
  assign err_remaining  = r_rem;
  assign AFpPCH         = r_afp;
  assign AFmPCH         = r_afm;
  assign AGCZ           = r_agcz;
  assign AGCEEC         = r_eec;
endmodule

// File: tb/tb_agc_cdu_interface.sv
// Self-checking bench: schedule-based reference model compared every cycle, plus directed literal checks.
module tb_agc_cdu_interface;
  localparam int P    = 24;
  localparam int W    = 3;
  localparam int Z    = 200;
  localparam int EMAX = 384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        atp = 1'b0, atm = 1'b0;
  logic        zero_req = 1'b0, ec_enable = 1'b0;
  logic        err_valid = 1'b0, err_abort = 1'b0;
  logic [10:0] err_count = '0;
  logic [14:0] angle;
  logic        dual_pulse_err, err_ready, err_sat, AFpPCH, AFmPCH, AGCZ, AGCEEC;
  logic [9:0]  err_remaining;

  agc_cdu_interface #(.PERIOD_CYC(P), .WIDTH_CYC(W), .ZERO_CYC(Z), .ERR_MAX(EMAX)) dut (
    .clk(clk), .rst(rst), .ATpPGH(atp), .ATmPGH(atm), .angle(angle),
    .dual_pulse_err(dual_pulse_err), .zero_req(zero_req), .ec_enable(ec_enable),
    .err_valid(err_valid), .err_count(err_count), .err_ready(err_ready),
    .err_abort(err_abort), .err_sat(err_sat), .err_remaining(err_remaining),
    .AFpPCH(AFpPCH), .AFmPCH(AFmPCH), .AGCZ(AGCZ), .AGCEEC(AGCEEC)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int due; bit p; bit m;} ev_t;
  ev_t q[$];
  int m_cyc = 0, m_angle = 0, m_dual = 0, m_sat = 0, m_eec = 1;
  int m_z = -1000000, m_t = 0, m_n = 0, m_dir = 0, m_end = 0;
  bit last_p = 0, last_m = 0;

  task automatic model_reset();
    m_angle = 0; m_dual = 0; m_sat = 0; m_eec = 1; m_z = -1000000;
    m_t = 0; m_n = 0; m_dir = 0; m_end = 0; last_p = 0; last_m = 0;
    q.delete();
  endtask

  // Compute the state after edge u from the inputs that edge samples.
  task automatic advance(input int u);
    int c, sc, mag, ph, idx, ne;
    bit zeroing, dp, dm, rp, rm;
    ev_t ev;
    c = u - 1;
    zeroing = zero_req || (m_z <= c && c <= m_z + Z - 1);
    dp = 0; dm = 0;
    while (q.size() > 0 && q[0].due == u) begin
      dp |= q[0].p; dm |= q[0].m; void'(q.pop_front());
    end
    if (zeroing) m_angle = 0;
    else if (dp && dm) m_dual = 1;
    else if (dp) m_angle = (m_angle + 1) % 32768;
    else if (dm) m_angle = (m_angle + 32767) % 32768;
    rp = atp && !last_p; rm = atm && !last_m;
    last_p = atp; last_m = atm;
    if (rp || rm) begin ev.due = u + 3; ev.p = rp; ev.m = rm; q.push_back(ev); end
    if (zero_req) m_z = u;
    m_eec = ec_enable ? 0 : 1;
    if (!(c >= m_t && c < m_end)) begin
      if (err_valid && !err_abort) begin
        sc = int'($signed(err_count));
        mag = (sc < 0) ? -sc : sc;
        if (mag > EMAX) begin m_sat = 1; mag = EMAX; end
        if (mag != 0) begin
          m_t = u; m_n = mag; m_dir = (sc < 0); m_end = u + mag * P;
          $display("cmd @%0d count=%0d pulses=%0d dir=%s", u, sc, mag, (sc < 0) ? "minus" : "plus");
        end
      end
    end else if (err_abort) begin
      ph = (c - m_t) % P; idx = (c - m_t) / P;
      ne = (ph < W) ? (m_t + idx * P + W) : u;
      if (ne < m_end) m_end = ne;
    end
    m_cyc = u;
  endtask

  always @(negedge clk) begin
    int c, ph, idx;
    int e_afp, e_afm, e_rem, e_rdy, e_agcz;
    if (rst) model_reset();
    c = m_cyc;
    if (c >= m_t && c < m_end) begin
      ph = (c - m_t) % P; idx = (c - m_t) / P;
      e_afp = (!m_dir && ph < W); e_afm = (m_dir && ph < W);
      e_rem = m_n - 1 - idx; e_rdy = 0;
    end else begin
      e_afp = 0; e_afm = 0; e_rem = 0; e_rdy = 1;
    end
    e_agcz = (m_z <= c && c <= m_z + Z - 1) ? 0 : 1;
    chk("angle", angle, m_angle);
    chk("dual_pulse_err", dual_pulse_err, m_dual);
    chk("err_sat", err_sat, m_sat);
    chk("err_ready", err_ready, e_rdy);
    chk("err_remaining", err_remaining, e_rem);
    chk("AFpPCH", AFpPCH, e_afp);
    chk("AFmPCH", AFmPCH, e_afm);
    chk("AF_exclusive", AFpPCH & AFmPCH, 0);
    chk("AGCZ", AGCZ, e_agcz);
    chk("AGCEEC", AGCEEC, m_eec);
    if (rst) begin model_reset(); m_cyc = c + 1; end
    else advance(c + 1);
  end

  // ---------------- pulse / zero monitor ----------------
  int tot_p = 0, tot_m = 0, tot_zlow = 0, tot_zbad = 0;
  int ncyc = 0, cur_w = 0, last_w = 0, last_rise = 0, last_gap = 0;
  logic prev_afp = 0, prev_afm = 0;
  always @(negedge clk) begin
    ncyc++;
    if (AFpPCH && !prev_afp) tot_p++;
    if (AFmPCH && !prev_afm) tot_m++;
    if ((AFpPCH && !prev_afp) || (AFmPCH && !prev_afm)) begin
      last_gap = ncyc - last_rise; last_rise = ncyc;
    end
    if (AFpPCH || AFmPCH) cur_w++;
    else if (prev_afp || prev_afm) begin last_w = cur_w; cur_w = 0; end
    if (!AGCZ) tot_zlow++;
    if (!AGCZ && angle != 0) tot_zbad++;
    prev_afp = AFpPCH; prev_afm = AFmPCH;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse_p(input int n);
    repeat (n) begin atp = 1; tick(4); atp = 0; tick(4); end
  endtask

  task automatic pulse_m(input int n);
    repeat (n) begin atm = 1; tick(4); atm = 0; tick(4); end
  endtask

  task automatic drive_cmd(input int cnt);
    err_count = 11'(cnt); err_valid = 1; tick(1); err_valid = 0;
  endtask

  task automatic wait_ready(input int limit);
    int k = 0;
    while (!err_ready && k < limit) begin tick(1); k++; end
    chk("ready_timeout", err_ready, 1);
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, m0, z0, zb0, k, half;
    tick(3);
    chk("rst_angle", angle, 0);
    chk("rst_ready", err_ready, 1);
    chk("rst_agcz", AGCZ, 1);
    chk("rst_agceec", AGCEEC, 1);
    chk("rst_afp", AFpPCH, 0);
    rst = 0; tick(2);
    ec_enable = 1; tick(2);
    chk("agceec_enabled", AGCEEC, 0);

    pulse_p(10); tick(6);
    chk("count_up_10", angle, 10);
    pulse_m(3); tick(6);
    chk("count_down_7", angle, 7);

    zero_req = 1; tick(1); zero_req = 0; tick(Z + 5);
    chk("zeroed", angle, 0);
    pulse_m(1); tick(6);
    chk("wrap_down", angle, 32767);
    pulse_p(1); tick(6);
    chk("wrap_up", angle, 0);

    pulse_p(2); tick(6);
    atp = 1; atm = 1; tick(4); atp = 0; atm = 0; tick(6);
    chk("dual_angle", angle, 2);
    chk("dual_flag", dual_pulse_err, 1);

    p0 = tot_p; m0 = tot_m;
    drive_cmd(384); wait_ready(EMAX * P + 20); tick(2);
    chk("pos_pulses", tot_p - p0, 384);
    chk("pos_no_afm", tot_m - m0, 0);
    chk("pos_width", last_w, W);
    chk("pos_spacing", last_gap, P);
    chk("pos_no_sat", err_sat, 0);

    p0 = tot_p; m0 = tot_m;
    drive_cmd(-500); wait_ready(EMAX * P + 20); tick(2);
    chk("neg_pulses", tot_m - m0, 384);
    chk("neg_no_afp", tot_p - p0, 0);
    chk("neg_width", last_w, W);
    chk("neg_sat", err_sat, 1);

    p0 = tot_p;
    drive_cmd(5);
    k = 0;
    while (!((tot_p - p0) == 2 && !AFpPCH) && k < 10 * P) begin tick(1); k++; end
    tick(5);
    err_abort = 1; tick(1); err_abort = 0; tick(1);
    chk("abort_ready", err_ready, 1);
    chk("abort_remaining", err_remaining, 0);
    tick(3 * P);
    chk("abort_pulses", tot_p - p0, 2);

    z0 = tot_zlow; zb0 = tot_zbad;
    zero_req = 1; tick(1); zero_req = 0;
    repeat ((Z + 20) / 2) begin atp = ~atp; tick(2); end
    atp = 0; tick(10);
    chk("zero_len", tot_zlow - z0, Z);
    chk("zero_angle_held", tot_zbad - zb0, 0);

    z0 = tot_zlow;
    zero_req = 1; tick(1); zero_req = 0; tick(49);
    zero_req = 1; tick(1); zero_req = 0; tick(Z + 10);
    chk("zero_restart_len", tot_zlow - z0, 50 + Z);

    half = 0;
    repeat (3000) begin
      if (half == 0) begin
        atp = 1'($urandom_range(0, 1));
        atm = 1'($urandom_range(0, 1));
      end
      half ^= 1;
      zero_req  = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) == 0) ec_enable = ~ec_enable;
      err_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) err_count = 11'($urandom_range(0, 2047));
      else err_count = 11'($urandom_range(0, 12) - 6);
      err_abort = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    atp = 0; atm = 0; zero_req = 0; err_valid = 0; err_abort = 0;
    wait_ready(EMAX * P + 20); tick(4);

    drive_cmd(3); tick(1);
    chk("pre_rst_afp", AFpPCH, 1);
    rst = 1; #1;
    chk("rst_mid_afp", AFpPCH, 0);
    chk("rst_mid_afm", AFmPCH, 0);
    chk("rst_mid_ready", err_ready, 1);
    tick(2); rst = 0; tick(3);
    chk("post_rst_afp", AFpPCH, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
